// File: rtl/cdb_arbiter_pkg.sv
// Shared completion-side types: FU index order, completion packet, default sizing.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package cdb_arbiter_pkg;

  localparam int DEF_NUM_FU       = 8;
  localparam int DEF_CDB_WIDTH    = 3;
  localparam int DEF_STARVE_LIMIT = 4;

  // FU index order shared with the issue stage; slot i belongs to FU i.
  typedef enum logic [2:0] {
    FU_ALU0   = 3'd0,
    FU_ALU1   = 3'd1,
    FU_ALU2   = 3'd2,
    FU_LS0    = 3'd3,
    FU_LS1    = 3'd4,
    FU_MULT0  = 3'd5,
    FU_MULT1  = 3'd6,
    FU_BRANCH = 3'd7
  } fu_idx_e;

  typedef struct packed {
    logic        valid;
    logic [5:0]  dest_prf_tag;
    logic [4:0]  rob_idx;
    logic [31:0] result;
    logic        take_branch;
    logic [31:0] br_target;
  } fu_complete_packet_t;

endpackage

// File: rtl/cdb_arbiter_rr_multi_picker.sv
// Picks up to max_cnt requesters, scanning from start upward with wrap.
// Latency: purely combinational.
// Backpressure: none; callers limit picks through max_cnt.
module rr_multi_picker #(
  parameter int NUM_FU    = 8,
  parameter int CDB_WIDTH = 3,
  parameter int PTR_W     = 3,
  parameter int CNT_W     = 2
) (
  input  logic [NUM_FU-1:0]                req,
  input  logic [PTR_W-1:0]                 start,
  input  logic [CNT_W-1:0]                 max_cnt,
  output logic [NUM_FU-1:0]                grant,
  output logic [CDB_WIDTH-1:0]             pick_vld,
  output logic [CDB_WIDTH-1:0][PTR_W-1:0]  pick_idx,
  output logic [CNT_W-1:0]                 pick_cnt,
  output logic [PTR_W-1:0]                 last_idx
);

  logic [PTR_W-1:0] scan_idx;
  logic [CNT_W-1:0] scan_cnt;

  // Walk all slots once in rotating order; the n-th hit lands in pick lane n.
  always_comb begin
    grant    = '0;
    pick_vld = '0;
    pick_idx = '0;
    last_idx = start;
    scan_cnt = '0;
    scan_idx = '0;
    for (int off = 0; off < NUM_FU; off++) begin
      scan_idx = PTR_W'((int'(start) + off) % NUM_FU);
      if (req[scan_idx] && (scan_cnt < max_cnt) && (scan_cnt < CNT_W'(CDB_WIDTH))) begin
        grant[scan_idx]    = 1'b1;
        pick_vld[scan_cnt] = 1'b1;
        pick_idx[scan_cnt] = scan_idx;
        last_idx           = scan_idx;
        scan_cnt           = scan_cnt + CNT_W'(1);
      end
    end
    pick_cnt = scan_cnt;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Holds one finished result per FU and grants up to CDB_WIDTH of them per cycle onto a registered CDB.
// Latency: FU result to CDB lane is 2 edges minimum (capture, then grant).
// Backpressure: fu_ready[i] drops while slot i is held and not granted this cycle.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU       = DEF_NUM_FU,
  parameter int CDB_WIDTH    = DEF_CDB_WIDTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int PTR_W        = $clog2(NUM_FU)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 squash,
  input  logic [NUM_FU-1:0]                    fu_valid_in,
  input  fu_complete_packet_t [NUM_FU-1:0]     fu_result_in,
  output logic [NUM_FU-1:0]                    fu_ready,
  output fu_complete_packet_t [CDB_WIDTH-1:0]  cdb_out,
  output logic [$clog2(NUM_FU):0]              slot_occupancy
);

  localparam int CNT_W = $clog2(CDB_WIDTH + 1);
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam int OCC_W = $clog2(NUM_FU) + 1;

  logic [NUM_FU-1:0]                slot_valid;
  fu_complete_packet_t [NUM_FU-1:0] slot_pkt;
  logic [NUM_FU-1:0][AGE_W-1:0]     age;
  logic [PTR_W-1:0]                 rr_ptr;

  logic [NUM_FU-1:0]                slot_valid_nxt;
  fu_complete_packet_t [NUM_FU-1:0] slot_pkt_nxt;
  logic [NUM_FU-1:0][AGE_W-1:0]     age_nxt;

  logic [NUM_FU-1:0]                starved;
  logic [NUM_FU-1:0]                normal_req;
  logic [NUM_FU-1:0]                grant;

  logic [NUM_FU-1:0]                p1_grant, p2_grant;
  logic [CDB_WIDTH-1:0]             p1_vld, p2_vld;
  logic [CDB_WIDTH-1:0][PTR_W-1:0]  p1_idx, p2_idx;
  logic [CNT_W-1:0]                 p1_cnt, p2_cnt;
  logic [PTR_W-1:0]                 p1_last, p2_last;
  logic [CNT_W-1:0]                 p2_max;

  logic [CDB_WIDTH-1:0]             lane_vld;
  logic [CDB_WIDTH-1:0][PTR_W-1:0]  lane_idx;
  logic [CNT_W-1:0]                 lane_off;
  logic [PTR_W-1:0]                 last_granted;

  // Split occupied slots into aged-out (forced priority) and ordinary requesters.
  always_comb begin
    starved    = '0;
    normal_req = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      starved[i]    = slot_valid[i] && (age[i] == AGE_W'(STARVE_LIMIT));
      normal_req[i] = slot_valid[i] && !starved[i];
    end
  end

  rr_multi_picker #(
    .NUM_FU   (NUM_FU),
    .CDB_WIDTH(CDB_WIDTH),
    .PTR_W    (PTR_W),
    .CNT_W    (CNT_W)
  ) u_starved_pick (
    .req      (starved),
    .start    (rr_ptr),
    .max_cnt  (CNT_W'(CDB_WIDTH)),
    .grant    (p1_grant),
    .pick_vld (p1_vld),
    .pick_idx (p1_idx),
    .pick_cnt (p1_cnt),
    .last_idx (p1_last)
  );

  assign p2_max = CNT_W'(CDB_WIDTH) - p1_cnt;

  rr_multi_picker #(
    .NUM_FU   (NUM_FU),
    .CDB_WIDTH(CDB_WIDTH),
    .PTR_W    (PTR_W),
    .CNT_W    (CNT_W)
  ) u_normal_pick (
    .req      (normal_req),
    .start    (rr_ptr),
    .max_cnt  (p2_max),
    .grant    (p2_grant),
    .pick_vld (p2_vld),
    .pick_idx (p2_idx),
    .pick_cnt (p2_cnt),
    .last_idx (p2_last)
  );

  assign grant        = p1_grant | p2_grant;
  assign fu_ready     = ~slot_valid | grant;
  assign last_granted = (p2_cnt != '0) ? p2_last : p1_last;

  // Starved picks take the low lanes; normal picks continue right after them.
  always_comb begin
    lane_vld = '0;
    lane_idx = '0;
    lane_off = '0;
    for (int k = 0; k < CDB_WIDTH; k++) begin
      if (CNT_W'(k) < p1_cnt) begin
        lane_vld[k] = p1_vld[k];
        lane_idx[k] = p1_idx[k];
      end else begin
        lane_off    = CNT_W'(k) - p1_cnt;
        lane_vld[k] = p2_vld[lane_off];
        lane_idx[k] = p2_idx[lane_off];
      end
    end
  end

  // Per-slot next state: capture, release on grant, saturating age, squash flush.
  always_comb begin
    slot_valid_nxt = slot_valid;
    slot_pkt_nxt   = slot_pkt;
    age_nxt        = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (slot_valid[i] && !grant[i]) begin
        age_nxt[i] = (age[i] == AGE_W'(STARVE_LIMIT)) ? age[i] : age[i] + AGE_W'(1);
      end
      if (fu_valid_in[i] && fu_ready[i]) begin
        slot_valid_nxt[i] = 1'b1;
        slot_pkt_nxt[i]   = fu_result_in[i];
      end else if (grant[i]) begin
        slot_valid_nxt[i] = 1'b0;
      end
    end
    if (squash) begin
      slot_valid_nxt = '0;
      age_nxt        = '0;
    end
  end

  // Slot, age and rotation-pointer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_valid <= '0;
      slot_pkt   <= '0;
      age        <= '0;
      rr_ptr     <= '0;
    end else begin
      slot_valid <= slot_valid_nxt;
      slot_pkt   <= slot_pkt_nxt;
      age        <= age_nxt;
      if ((|grant) && !squash) begin
        rr_ptr <= PTR_W'((int'(last_granted) + 1) % NUM_FU);
      end
    end
  end

  // Registered CDB lanes; granted slots are driven one cycle after the grant.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cdb_out <= '0;
    end else begin
      for (int k = 0; k < CDB_WIDTH; k++) begin
        if (squash || !lane_vld[k]) begin
          cdb_out[k] <= '0;
        end else begin
          cdb_out[k]       <= slot_pkt[lane_idx[k]];
          cdb_out[k].valid <= 1'b1;
        end
      end
    end
  end

  // Occupied-slot count from registered slot state.
  always_comb begin
    slot_occupancy = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      slot_occupancy = slot_occupancy + OCC_W'(slot_valid[i]);
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with STARVE_LIMIT=2.
// Inputs change on the falling edge; outputs are checked on the falling edge.
// FU drivers never present while fu_ready is low.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NF = 8;
  localparam int CW = 3;
  localparam int SL = 2;

  logic                          clock = 1'b0;
  logic                          reset = 1'b0;
  logic                          squash = 1'b0;
  logic [NF-1:0]                 fu_valid_in = '0;
  fu_complete_packet_t [NF-1:0]  fu_result_in = '0;
  logic [NF-1:0]                 fu_ready;
  fu_complete_packet_t [CW-1:0]  cdb_out;
  logic [3:0]                    slot_occupancy;

  int n_checks = 0;
  int n_errors = 0;
  int viol     = 0;

  always #5 clock = ~clock;

  cdb_arbiter #(
    .NUM_FU      (NF),
    .CDB_WIDTH   (CW),
    .STARVE_LIMIT(SL)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .squash        (squash),
    .fu_valid_in   (fu_valid_in),
    .fu_result_in  (fu_result_in),
    .fu_ready      (fu_ready),
    .cdb_out       (cdb_out),
    .slot_occupancy(slot_occupancy)
  );

  function automatic fu_complete_packet_t mkpkt(int fu, int ph);
    fu_complete_packet_t p;
    p.valid        = 1'b1;
    p.dest_prf_tag = 6'(((ph & 7) << 3) | fu);
    p.rob_idx      = 5'(fu);
    p.result       = 32'hA000_0000 + 32'(ph * 256 + fu);
    p.take_branch  = (fu == 7);
    p.br_target    = p.result + 32'd4;
    return p;
  endfunction

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic present(logic [NF-1:0] mask, int ph);
    fu_valid_in = mask;
    for (int i = 0; i < NF; i++) begin
      fu_result_in[i] = mask[i] ? mkpkt(i, ph) : '0;
    end
  endtask

  task automatic lane(int k, int fu, int ph, string tag);
    check(tag, 128'(cdb_out[k]), 128'(mkpkt(fu, ph)));
  endtask

  task automatic lane_off(int k, string tag);
    check(tag, 128'(cdb_out[k].valid), 128'(0));
  endtask

  function automatic logic [2:0] lane_valids();
    return {cdb_out[2].valid, cdb_out[1].valid, cdb_out[0].valid};
  endfunction

  // Count any FU presenting while not ready (protocol violation by the drivers).
  always @(negedge clock) begin
    #2;
    if (reset && ((fu_valid_in & ~fu_ready) != '0)) viol++;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    #1;
    check("rst_ready", 128'(fu_ready), 128'(8'hFF));
    check("rst_cdb", 128'(lane_valids()), 128'(3'b000));
    check("rst_occ", 128'(slot_occupancy), 128'(0));
    @(negedge clock);
    reset = 1'b1;

    // Sparse completion: FU2 and FU5 with rr_ptr=0
    present(8'b0010_0100, 1);
    @(negedge clock);
    check("sparse_occ", 128'(slot_occupancy), 128'(2));
    check("sparse_ready", 128'(fu_ready), 128'(8'hFF));
    present('0, 0);
    @(negedge clock);
    lane(0, 2, 1, "sparse_l0");
    lane(1, 5, 1, "sparse_l1");
    lane_off(2, "sparse_l2");
    check("sparse_rr", 128'(dut.rr_ptr), 128'(6));
    check("sparse_occ_empty", 128'(slot_occupancy), 128'(0));

    // Reset in mid-traffic: slots 0,3,5 held while CDB is busy
    present(8'b0010_1001, 2);
    @(negedge clock);
    present(8'b0010_1001, 3);
    @(negedge clock);
    lane(0, 0, 2, "midrst_pre_l0");
    lane(2, 5, 2, "midrst_pre_l2");
    check("midrst_pre_occ", 128'(slot_occupancy), 128'(3));
    present('0, 0);
    #1 reset = 1'b0;
    #1;
    check("midrst_cdb", 128'(lane_valids()), 128'(3'b000));
    check("midrst_ready", 128'(fu_ready), 128'(8'hFF));
    check("midrst_occ", 128'(slot_occupancy), 128'(0));
    check("midrst_rr", 128'(dut.rr_ptr), 128'(0));
    @(negedge clock);
    reset = 1'b1;

    // Full burst: all 8 FUs valid once, rr_ptr=0
    present(8'hFF, 4);
    @(negedge clock);
    check("burst_occ8", 128'(slot_occupancy), 128'(8));
    check("burst_ready0", 128'(fu_ready), 128'(8'h07));
    present('0, 0);
    @(negedge clock);
    lane(0, 0, 4, "burst1_l0");
    lane(1, 1, 4, "burst1_l1");
    lane(2, 2, 4, "burst1_l2");
    check("burst_ready1", 128'(fu_ready), 128'(8'h3F));
    check("burst_occ5", 128'(slot_occupancy), 128'(5));
    @(negedge clock);
    lane(0, 3, 4, "burst2_l0");
    lane(1, 4, 4, "burst2_l1");
    lane(2, 5, 4, "burst2_l2");
    check("burst_ready2", 128'(fu_ready), 128'(8'hFF));
    check("burst_occ2", 128'(slot_occupancy), 128'(2));
    @(negedge clock);
    lane(0, 6, 4, "burst3_l0");
    lane(1, 7, 4, "burst3_l1");
    lane_off(2, "burst3_l2");
    check("burst_occ0", 128'(slot_occupancy), 128'(0));
    check("burst_rr", 128'(dut.rr_ptr), 128'(0));

    // Back-to-back FU0: one result per cycle, always ready
    for (int k = 0; k < 8; k++) begin
      check($sformatf("b2b_ready_%0d", k), 128'(fu_ready[0]), 128'(1));
      if (k >= 2 && k <= 6) begin
        lane(0, 0, k - 2, $sformatf("b2b_l0_%0d", k));
        lane_off(1, $sformatf("b2b_l1_%0d", k));
      end
      if (k == 7) lane_off(0, "b2b_drained");
      if (k < 5) present(8'h01, k);
      else present('0, 0);
      @(negedge clock);
    end
    check("b2b_rr", 128'(dut.rr_ptr), 128'(1));

    // Starvation: FU7 completes once, FUs 0-6 re-present whenever ready (rr_ptr=1)
    present(8'hFF, 5);
    @(negedge clock);
    check("starve_ready1", 128'(fu_ready), 128'(8'h0E));
    present(fu_ready & 8'h7F, 6);
    @(negedge clock);
    lane(0, 1, 5, "starve1_l0");
    lane(1, 2, 5, "starve1_l1");
    lane(2, 3, 5, "starve1_l2");
    check("starve_ready2", 128'(fu_ready), 128'(8'h70));
    present(fu_ready & 8'h7F, 7);
    @(negedge clock);
    lane(0, 4, 5, "starve2_l0");
    lane(1, 5, 5, "starve2_l1");
    lane(2, 6, 5, "starve2_l2");
    check("starve_ready3", 128'(fu_ready), 128'(8'h83));
    present(fu_ready & 8'h7F, 0);
    @(negedge clock);
    lane(0, 7, 5, "starve3_l0_fu7");
    lane(1, 0, 5, "starve3_l1");
    lane(2, 1, 6, "starve3_l2");
    present('0, 0);
    repeat (5) @(negedge clock);
    check("drain_occ", 128'(slot_occupancy), 128'(0));

    // Squash: slots 1,4,6 held, squash with a new FU2 result
    present(8'b0101_0010, 1);
    @(negedge clock);
    check("squash_pre_occ", 128'(slot_occupancy), 128'(3));
    squash = 1'b1;
    present(8'b0000_0100, 2);
    @(negedge clock);
    squash = 1'b0;
    present('0, 0);
    check("squash_occ", 128'(slot_occupancy), 128'(0));
    check("squash_cdb", 128'(lane_valids()), 128'(3'b000));
    check("squash_ready", 128'(fu_ready), 128'(8'hFF));
    @(negedge clock);
    check("squash_fu2_dropped_cdb", 128'(lane_valids()), 128'(3'b000));
    check("squash_fu2_dropped_occ", 128'(slot_occupancy), 128'(0));

    check("proto_viol", 128'(viol), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Completion-side scheduler for the functional units fed by the issue FIFOs: ALU x3, LS x2, MULT x2 and BRANCH.
- Each FU deposits a finished result into a one-entry holding slot inside this block.
- The block grants up to CDB_WIDTH slots per cycle onto the registered common data bus, using a rotating-priority scheme with anti-starvation aging.
- It back-pressures each FU through fu_ready, which the issue stage folds into its per-FU read enables.

Parameters:
- NUM_FU, 8, number of completing functional units (index = FU enum order).
- CDB_WIDTH, 3, CDB lanes per cycle.
- STARVE_LIMIT, 4, wait cycles after which a held slot gets forced priority.
- PTR_W, $clog2(NUM_FU), width of the round-robin pointer.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- squash  in  1  synchronous branch-mispredict flush.
- fu_valid_in  in  NUM_FU  FU i presents a result this cycle.
- fu_result_in  in  NUM_FU x FU_COMPLETE_PACKET  result payload per FU.
- fu_ready  out  NUM_FU  FU i may deliver a result this cycle.
- cdb_out  out  CDB_WIDTH x FU_COMPLETE_PACKET  registered CDB lanes, each with a .valid field.
- slot_occupancy  out  $clog2(NUM_FU)+1  count of occupied holding slots (registered state).

Behaviour:
- Reset (reset=0, asynchronous):
  - slot_valid, age and rr_ptr clear to 0.
  - All cdb_out lanes clear to 0 (valid=0).
  - Because fu_ready is derived combinationally, fu_ready is all 1 while reset is held.
- State per FU: slot_valid[i], slot_pkt[i], age[i] (saturating at STARVE_LIMIT). Global state: rr_ptr.
- fu_ready[i] = !slot_valid[i] || grant[i]. It is combinational in the same cycle and does not depend on fu_valid_in.
- Capture: when fu_valid_in[i] && fu_ready[i], slot_pkt[i] <= fu_result_in[i] and slot_valid[i] <= 1 at the next edge. If fu_valid_in[i] is high while fu_ready[i]=0, that is an FU protocol violation; the slot is unchanged and the bench asserts on it.
- Grant selection (combinational, over occupied slots only):
  - Pass 1: slots with age == STARVE_LIMIT, scanned from rr_ptr upward with wrap.
  - Pass 2: remaining slots, same scan order.
  - Stop at CDB_WIDTH grants.
  - The k-th chosen slot maps to lane k, so lanes fill contiguously from lane 0.
- CDB latency: a slot granted in cycle t appears on cdb_out[k] with valid=1 in cycle t+1. Ungranted lanes have valid=0. The minimum FU-result-to-CDB latency is 2 edges (capture, then grant).
- Slot update on grant:
  - Granted and refilled in the same cycle: slot reloads with the new packet and age becomes 0.
  - Granted and not refilled: slot_valid becomes 0.
- Age: for each slot that is valid and not granted, age increments, saturating at STARVE_LIMIT. Age resets to 0 on grant or when the slot is empty.
- rr_ptr: when there is at least one grant, rr_ptr becomes (index of the last granted slot + 1) mod NUM_FU. With no grants it holds.
- Squash (synchronous):
  - Next edge: all slot_valid, age and cdb_out.valid clear to 0.
  - Inputs captured in the squash cycle are discarded.
  - Grants computed in the squash cycle are not driven.
  - rr_ptr holds.
- slot_occupancy = popcount(slot_valid), range 0..NUM_FU.

Decomposition:
- Shared package (sys_defs):
  - FU_COMPLETE_PACKET: valid, dest_prf_tag, rob_idx, result, branch fields.
  - `NUM_FU, `CDB_WIDTH, `STARVE_LIMIT.
  - The FU index enum shared with the issue stage.
- One natural sub-module: rr_multi_picker. It takes a request vector, a start pointer and a max count, and returns up to CDB_WIDTH one-hot picks plus the last-picked index. It is instantiated twice (starved pass, normal pass), with the second pass masked by the first and limited to the remaining lanes.

Test Plan:
- Reset in mid-traffic:
  - Stimulus: slots 0, 3 and 5 held; drive reset=0 between edges.
  - Required response: cdb_out valid = 000 immediately, fu_ready = 8'hFF, slot_occupancy = 0.
- Sparse completion:
  - Stimulus: fu_valid_in = 8'b0010_0100 with rr_ptr=0.
  - Required response: 2 edges later lane0 carries FU2's tag, lane1 carries FU5's tag, lane2 invalid; rr_ptr = 6.
- Full burst:
  - Stimulus: all 8 FUs valid for one cycle, rr_ptr=0.
  - Required response: successive CDB cycles deliver FUs {0,1,2}, {3,4,5}, then {6,7} with lane2 invalid. fu_ready is low for held, ungranted slots in each cycle.
- Starvation:
  - Stimulus: STARVE_LIMIT=2; FU7 completes once; FUs 0–6 re-present a result every cycle.
  - Required response: by the third grant cycle FU7 has age 2, so lane0 = FU7 and the remaining lanes follow rotating order.
- Squash:
  - Stimulus: slots 1, 4 and 6 held; squash=1 together with fu_valid_in[2]=1.
  - Required response: next cycle slot_occupancy = 0, all CDB lanes invalid, FU2's result dropped.
- Back-to-back same FU:
  - Stimulus: FU0 presents a result every cycle with no other traffic.
  - Required response: fu_ready[0] stays 1 throughout, and lane0 carries one FU0 result per cycle in order.
